// File: rtl/arith_mult_64bgoldilocks_acc_pkg.sv
// Shared constants and types for the Goldilocks accumulator: field prime, FSM states and the
// input-to-result latency helper.
package arith_mult_64bgoldilocks_acc_pkg;

  localparam logic [63:0] GOLDILOCKS_PRIME = 64'hFFFF_FFFF_0000_0001;

  typedef enum logic {IDLE, ACC} acc_state_e;

  // Cycles from the eop term being sampled to out_avail.
  function automatic int unsigned get_latency(input int unsigned in_pipe);
    return in_pipe + 1;
  endfunction

endpackage

// File: rtl/arith_goldilocks_add_mod.sv
// Combinational modular add a +p b over the Goldilocks prime; both operands must be canonical.
module arith_goldilocks_add_mod
  import arith_mult_64bgoldilocks_acc_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] sum_o
);

  logic [64:0] sum_full;

  always_comb begin
    sum_full = {1'b0, a_i} + {1'b0, b_i};
    // s - p always fits in 64 bits when s >= p, so the modulo-2^64 subtract is exact.
    if (sum_full >= {1'b0, GOLDILOCKS_PRIME}) begin
      sum_o = sum_full[63:0] - GOLDILOCKS_PRIME;
    end else begin
      sum_o = sum_full[63:0];
    end
  end

endmodule

// File: rtl/arith_mult_64bgoldilocks_acc.sv
// Framed mod-p accumulator for Goldilocks products; emits the sum and term count on eop.
// Optional sticky err port enabled by ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN.
module arith_mult_64bgoldilocks_acc
  import arith_mult_64bgoldilocks_acc_pkg::*;
#(
  parameter int unsigned IN_PIPE = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             in_avail,
  input  logic [63:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_avail,
  output logic [63:0]      out_data,
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
  output logic [CNT_W-1:0] out_cnt,
  output logic             err
`else
  output logic [CNT_W-1:0] out_cnt
`endif
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic        avail_s;
  logic [63:0] data_s;
  logic        sop_s;
  logic        eop_s;

  if (IN_PIPE != 0) begin : g_in_pipe
    logic        avail_q;
    logic [63:0] data_q;
    logic        sop_q;
    logic        eop_q;

    always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
        avail_q <= 1'b0;
        data_q  <= '0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end else begin
        avail_q <= in_avail;
        if (in_avail) begin
          data_q <= in_data;
          sop_q  <= in_sop;
          eop_q  <= in_eop;
        end
      end
    end

    assign avail_s = avail_q;
    assign data_s  = data_q;
    assign sop_s   = sop_q;
    assign eop_s   = eop_q;
  end else begin : g_no_pipe
    assign avail_s = in_avail;
    assign data_s  = in_data;
    assign sop_s   = in_sop;
    assign eop_s   = in_eop;
  end

  acc_state_e       state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_avail_q, out_avail_d;
  logic [63:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [63:0]      sum;
  logic [CNT_W-1:0] cnt_inc;

  arith_goldilocks_add_mod u_add_mod (
    .a_i   (acc_q),
    .b_i   (data_s),
    .sum_o (sum)
  );

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_avail_d = 1'b0;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    if (avail_s) begin
      // sop always (re)starts a frame, whether idle or mid-frame.
      if (sop_s) begin
        acc_d = data_s;
        cnt_d = CntOne;
        if (eop_s) begin
          out_avail_d = 1'b1;
          out_data_d  = data_s;
          out_cnt_d   = CntOne;
          state_d     = IDLE;
        end else begin
          state_d = ACC;
        end
      end else if (state_q == ACC) begin
        acc_d = sum;
        cnt_d = cnt_inc;
        if (eop_s) begin
          out_avail_d = 1'b1;
          out_data_d  = sum;
          out_cnt_d   = cnt_inc;
          state_d     = IDLE;
        end
      end
    end
  end

`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (avail_s) begin
      if ((state_q == IDLE && !sop_s) || (state_q == ACC && sop_s) ||
          (data_s >= GOLDILOCKS_PRIME) || (state_q == ACC && !sop_s && cnt_q == CntMax)) begin
        err_d = 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_avail_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_avail_q <= out_avail_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out_avail = out_avail_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_arith_mult_64bgoldilocks_acc.sv
// Self-checking bench: vector table plus hand sequences, results checked via a scoreboard queue.
module tb_arith_mult_64bgoldilocks_acc;

  localparam int unsigned IN_PIPE = 1;
  localparam int unsigned CNT_W   = 4;
  localparam int          LAT     = IN_PIPE + 1;
  localparam logic [63:0] P       = 64'hFFFF_FFFF_0000_0001;

  typedef struct {
    logic [63:0]      data;
    logic             sop;
    logic             eop;
    int unsigned      gap;
    logic             push;
    logic [63:0]      edata;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  typedef struct {
    logic [63:0]      data;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             a_rst = 1'b1;
  logic             in_avail = 1'b0;
  logic [63:0]      in_data = '0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic             out_avail;
  logic [63:0]      out_data;
  logic [CNT_W-1:0] out_cnt;
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
  logic             err;
`endif

  int               compared = 0;
  int               failed = 0;
  int               cyc = 0;
  exp_t             sb[$];
  vec_t             tbl[$];
  logic [63:0]      last_data = '0;
  logic [CNT_W-1:0] last_cnt = '0;

  arith_mult_64bgoldilocks_acc #(
    .IN_PIPE (IN_PIPE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .in_avail  (in_avail),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_avail (out_avail),
    .out_data  (out_data),
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
    .out_cnt   (out_cnt),
    .err       (err)
`else
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: pop on each pulse, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (!a_rst) begin
      if (out_avail) begin
        if (sb.size() == 0) begin
          check("unexpected_out_avail", 64'(out_avail), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_cnt", 64'(out_cnt), 64'(e.cnt));
          check("latency_cycle", 64'(cyc), 64'(e.cyc));
          last_data = e.data;
          last_cnt  = e.cnt;
        end
      end else begin
        check("held_out_data", out_data, last_data);
        check("held_out_cnt", 64'(out_cnt), 64'(last_cnt));
      end
    end
  end

  task automatic drive(input logic [63:0] d, input logic s, input logic e, input logic push,
                       input logic [63:0] ed, input logic [CNT_W-1:0] ec);
    @(posedge clk);
    #1;
    in_avail = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    if (push) sb.push_back('{data: ed, cnt: ec, cyc: cyc + LAT});
  endtask

  // Idle cycles carry random junk on the data/framing lines to show they are ignored.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_avail = 1'b0;
      in_data  = {$urandom, $urandom};
      in_sop   = 1'($urandom);
      in_eop   = 1'($urandom);
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    a_rst    = 1'b1;
    in_avail = 1'b0;
    sb.delete();
    last_data = '0;
    last_cnt  = '0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_cnt", 64'(out_cnt), 64'd0);
  endtask

  task automatic check_err(input logic expv);
`ifdef ARITH_MULT_64BGOLDILOCKS_ACC_ERR_CHECK_EN
    check("err", 64'(err), 64'(expv));
`endif
  endtask

  function automatic void add(input logic [63:0] d, input logic s, input logic e,
                              input int unsigned gap, input logic push,
                              input logic [63:0] ed, input int ec);
    tbl.push_back('{data: d, sop: s, eop: e, gap: gap, push: push, edata: ed,
                    ecnt: CNT_W'(ec)});
  endfunction

  initial begin
    // Frame {1,2,3} twice back-to-back.
    for (int k = 0; k < 2; k++) begin
      add(64'd1, 1, 0, 0, 0, 0, 0);
      add(64'd2, 0, 0, 0, 0, 0, 0);
      add(64'd3, 0, 1, 0, 1, 64'd6, 3);
    end
    add(P - 1, 1, 0, 0, 0, 0, 0);
    add(64'd1, 0, 1, 0, 1, 64'd0, 2);
    add(P - 1, 1, 0, 0, 0, 0, 0);
    add(P - 1, 0, 1, 0, 1, 64'hFFFF_FFFE_FFFF_FFFF, 2);
    add(64'h8000_0000_0000_0000, 1, 0, 0, 0, 0, 0);
    add(64'h8000_0000_0000_0000, 0, 1, 2, 1, 64'h0000_0000_FFFF_FFFF, 2);
    // Single-term frame immediately followed by another frame.
    add(64'd5, 1, 1, 0, 1, 64'd5, 1);
    add(64'd4, 1, 0, 0, 0, 0, 0);
    add(64'd6, 0, 1, 1, 1, 64'd10, 2);
    // Frame {10,20,30} with random gaps.
    add(64'd10, 1, 0, $urandom_range(0, 7), 0, 0, 0);
    add(64'd20, 0, 0, $urandom_range(0, 7), 0, 0, 0);
    add(64'd30, 0, 1, $urandom_range(0, 7), 1, 64'd60, 3);

    repeat (3) @(negedge clk);
    check("reset_out_avail", 64'(out_avail), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_cnt", 64'(out_cnt), 64'd0);
    check_err(1'b0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].data, tbl[i].sop, tbl[i].eop, tbl[i].push, tbl[i].edata, tbl[i].ecnt);
      if (tbl[i].gap != 0) idle(tbl[i].gap);
    end
    drain();
    check_err(1'b0);

    // sop inside a frame restarts it; also restart straight into a single-term frame.
    drive(64'd100, 1, 0, 0, 0, 0);
    drive(64'd200, 0, 0, 0, 0, 0);
    drive(64'd7, 1, 0, 0, 0, 0);
    drive(64'd8, 0, 0, 0, 0, 0);
    drive(64'd9, 0, 1, 1, 64'd24, 3);
    drive(64'd1, 1, 0, 0, 0, 0);
    drive(64'd42, 1, 1, 1, 64'd42, 1);
    drain();
    check_err(1'b1);

    // Reset after the second term of a 4-term frame: only the next frame reports.
    do_reset();
    check_err(1'b0);
    drive(64'd1, 1, 0, 0, 0, 0);
    drive(64'd2, 0, 0, 0, 0, 0);
    do_reset();
    drive(64'd7, 1, 1, 1, 64'd7, 1);
    drain();
    check_err(1'b0);

    // Out-of-range term passes straight through a single-term frame.
    drive(P, 1, 1, 1, P, 1);
    drain();
    check_err(1'b1);

    // 20 ones: sum keeps going, count sticks at 15.
    do_reset();
    for (int i = 0; i < 20; i++) drive(64'd1, i == 0, i == 19, i == 19, 64'd20, 15);
    drain();
    check_err(1'b1);

    // Stray term in IDLE is dropped.
    do_reset();
    drive(64'd99, 0, 1, 0, 0, 0);
    drive(64'd3, 1, 1, 1, 64'd3, 1);
    drain();
    check_err(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
